// File: rtl/mcu51_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mcu51_isa_pkg
// Brief    : 8051 ISA definitions shared by the fetch path and control unit:
//            assembler FSM states, opcode constants, instruction length.
// Revision : 1.0 - initial release
// ============================================================================
package mcu51_isa_pkg;

    typedef enum logic [1:0] {
        ST_OPC  = 2'd0,
        ST_OP1  = 2'd1,
        ST_OP2  = 2'd2,
        ST_HOLD = 2'd3
    } asm_state_t;

    localparam logic [7:0] MOV_DIR_DIR = 8'h85;
    localparam logic [7:0] MOV_DIR_IMM = 8'h75;
    localparam logic [7:0] LJMP        = 8'h02;
    localparam logic [7:0] LCALL       = 8'h12;
    localparam logic [7:0] MOV_DPTR    = 8'h90;
    localparam logic [7:0] SJMP        = 8'h80;

    // Total bytes (opcode included) occupied by an instruction.
    function automatic logic [1:0] instr_length(input logic [7:0] opcode);
        logic [1:0] len;
        len = 2'd1;
        // AJMP/ACALL family: every opcode with low nibble 1
        if (opcode[3:0] == 4'h1)
            len = 2'd2;
        // MOV dir,Rn / MOV Rn,dir / MOV Rn,#data
        if ((opcode[7:3] == 5'b10001) || (opcode[7:3] == 5'b10101) ||
            (opcode[7:3] == 5'b01111))
            len = 2'd2;
        case (opcode)
            8'h86, 8'h87, 8'hA6, 8'hA7, 8'hE5, 8'hF5,
            8'h74, SJMP, 8'h60, 8'h70:                        len = 2'd2;
            MOV_DIR_DIR, MOV_DIR_IMM, LJMP, LCALL, MOV_DPTR:  len = 2'd3;
            default: ;
        endcase
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/isa_len_decode.sv
`default_nettype none
// ============================================================================
// Module   : isa_len_decode
// Brief    : Combinational opcode-to-instruction-length decoder.
// Revision : 1.0 - initial release
// ============================================================================
module isa_len_decode
    import mcu51_isa_pkg::*;
(
    input  logic [7:0] i_opcode,
    output logic [1:0] o_len
);

    assign o_len = instr_length(i_opcode);

endmodule
`default_nettype wire

// File: rtl/instr_byte_assembler.sv
`default_nettype none
// ============================================================================
// Module   : instr_byte_assembler
// Brief    : Assembles code-memory bytes into complete 8051 instructions and
//            hands them to the control unit over a valid/take handshake.
// Revision : 1.0 - initial release
// ============================================================================
module instr_byte_assembler
    import mcu51_isa_pkg::*;
#(
    parameter logic [7:0] NOP_OPCODE = 8'h00,
    parameter int         REL_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       i_code_data,
    input  logic             i_code_valid,
    input  logic             i_flush,
    input  logic             i_instr_take,
    output logic             o_fetch_ready,
    output logic             o_instr_valid,
    output logic [7:0]       o_ir,
    output logic [7:0]       o_opnd1,
    output logic [7:0]       o_opnd2,
    output logic [REL_W-1:0] o_rel,
    output logic [1:0]       o_instr_len,
    output logic             o_overflow
);

    asm_state_t       r_state;
    logic [7:0]       r_ir;
    logic [7:0]       r_opnd1;
    logic [7:0]       r_opnd2;
    logic [REL_W-1:0] r_rel;
    logic [1:0]       r_len;
    logic             r_valid;
    logic [7:0]       r_pend;
    logic             r_pend_valid;
    logic             r_overflow;

    logic [1:0]       w_code_len;
    logic [1:0]       w_pend_len;
    logic [REL_W-1:0] w_code_rel;
    logic             w_fetch_ready;

    isa_len_decode u_len_code (
        .i_opcode (i_code_data),
        .o_len    (w_code_len)
    );

    isa_len_decode u_len_pend (
        .i_opcode (r_pend),
        .o_len    (w_pend_len)
    );

    assign w_code_rel    = {{(REL_W-8){i_code_data[7]}}, i_code_data};
    assign w_fetch_ready = !((r_state == ST_HOLD) && r_pend_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_OPC;
            r_ir         <= NOP_OPCODE;
            r_opnd1      <= 8'h00;
            r_opnd2      <= 8'h00;
            r_rel        <= '0;
            r_len        <= 2'd0;
            r_valid      <= 1'b0;
            r_pend       <= 8'h00;
            r_pend_valid <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (i_flush) begin
            r_state      <= ST_OPC;
            r_valid      <= 1'b0;
            r_pend_valid <= 1'b0;
            r_ir         <= NOP_OPCODE;
        end else begin
            case (r_state)
                ST_OPC: begin
                    if (i_code_valid) begin
                        r_ir    <= i_code_data;
                        r_len   <= w_code_len;
                        r_opnd1 <= 8'h00;
                        r_opnd2 <= 8'h00;
                        if (w_code_len >= 2'd2) begin
                            r_state <= ST_OP1;
                        end else begin
                            r_state <= ST_HOLD;
                            r_valid <= 1'b1;
                        end
                    end
                end
                ST_OP1: begin
                    if (i_code_valid) begin
                        r_opnd1 <= i_code_data;
                        r_rel   <= w_code_rel;
                        if (r_len == 2'd3) begin
                            r_state <= ST_OP2;
                        end else begin
                            r_state <= ST_HOLD;
                            r_valid <= 1'b1;
                        end
                    end
                end
                ST_OP2: begin
                    if (i_code_valid) begin
                        r_opnd2 <= i_code_data;
                        r_rel   <= w_code_rel;
                        r_state <= ST_HOLD;
                        r_valid <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (i_instr_take && !r_pend_valid) begin
                        if (i_code_valid) begin
                            r_ir    <= i_code_data;
                            r_len   <= w_code_len;
                            r_opnd1 <= 8'h00;
                            r_opnd2 <= 8'h00;
                            if (w_code_len >= 2'd2) begin
                                r_state <= ST_OP1;
                                r_valid <= 1'b0;
                            end
                        end else begin
                            r_state <= ST_OPC;
                            r_valid <= 1'b0;
                        end
                    end else if (i_instr_take) begin
                        // Held byte becomes the opcode; a same-cycle byte follows it.
                        r_pend_valid <= 1'b0;
                        r_ir         <= r_pend;
                        r_len        <= w_pend_len;
                        r_opnd1      <= 8'h00;
                        r_opnd2      <= 8'h00;
                        if (w_pend_len >= 2'd2) begin
                            r_state <= ST_OP1;
                            r_valid <= 1'b0;
                            if (i_code_valid) begin
                                r_opnd1 <= i_code_data;
                                r_rel   <= w_code_rel;
                                if (w_pend_len == 2'd3) begin
                                    r_state <= ST_OP2;
                                end else begin
                                    r_state <= ST_HOLD;
                                    r_valid <= 1'b1;
                                end
                            end
                        end else if (i_code_valid) begin
                            r_pend       <= i_code_data;
                            r_pend_valid <= 1'b1;
                        end
                    end else if (i_code_valid) begin
                        if (r_pend_valid) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_pend       <= i_code_data;
                            r_pend_valid <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_OPC;
            endcase
        end
    end

    assign o_fetch_ready = w_fetch_ready;
    assign o_instr_valid = r_valid;
    assign o_ir          = r_ir;
    assign o_opnd1       = r_opnd1;
    assign o_opnd2       = r_opnd2;
    assign o_rel         = r_rel;
    assign o_instr_len   = r_len;
    assign o_overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_instr_byte_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_byte_assembler
// Brief    : Directed self-checking bench with a byte-stream reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_byte_assembler;

    logic        clk;
    logic        reset;
    logic [7:0]  code_data;
    logic        code_valid;
    logic        flush;
    logic        instr_take;
    logic        fetch_ready;
    logic        instr_valid;
    logic [7:0]  ir;
    logic [7:0]  opnd1;
    logic [7:0]  opnd2;
    logic [15:0] rel;
    logic [1:0]  instr_len;
    logic        overflow;

    logic [7:0]  dec_op;
    logic [1:0]  dec_len;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    // Model: queue of accepted bytes not yet retired by a take.
    logic [7:0]  m_q[$];
    logic [15:0] m_rel;
    bit          m_ovf;

    instr_byte_assembler #(.NOP_OPCODE(8'h00), .REL_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_code_data   (code_data),
        .i_code_valid  (code_valid),
        .i_flush       (flush),
        .i_instr_take  (instr_take),
        .o_fetch_ready (fetch_ready),
        .o_instr_valid (instr_valid),
        .o_ir          (ir),
        .o_opnd1       (opnd1),
        .o_opnd2       (opnd2),
        .o_rel         (rel),
        .o_instr_len   (instr_len),
        .o_overflow    (overflow)
    );

    isa_len_decode u_dec (
        .i_opcode (dec_op),
        .o_len    (dec_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int tb_len(input logic [7:0] op);
        int v;
        v = int'(op);
        if ((v >= 'h88 && v <= 'h8F) || (v >= 'hA8 && v <= 'hAF) || (v >= 'h78 && v <= 'h7F))
            return 2;
        if (v == 'h86 || v == 'h87 || v == 'hA6 || v == 'hA7 || v == 'hE5 || v == 'hF5 ||
            v == 'h74 || v == 'h80 || v == 'h60 || v == 'h70 || (v % 16) == 1)
            return 2;
        if (v == 'h85 || v == 'h75 || v == 'h02 || v == 'h12 || v == 'h90)
            return 3;
        return 1;
    endfunction

    function automatic bit m_presented();
        if (m_q.size() == 0) return 1'b0;
        return m_q.size() >= tb_len(m_q[0]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Accept a byte into the stream; non-opcode bytes update the rel value.
    task automatic m_push(input logic [7:0] b);
        int idx;
        m_q.push_back(b);
        idx = 0;
        while (idx < m_q.size() - 1) idx += tb_len(m_q[idx]);
        if (idx != m_q.size() - 1) m_rel = {{8{b[7]}}, b};
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_q.delete();
            m_rel = 16'h0000;
            m_ovf = 1'b0;
        end else if (flush) begin
            m_q.delete();
        end else if (instr_take && m_presented()) begin
            int l;
            l = tb_len(m_q[0]);
            for (int k = 0; k < l; k++) void'(m_q.pop_front());
            if (code_valid) m_push(code_data);
        end else if (code_valid) begin
            if (m_presented() && m_q.size() > tb_len(m_q[0])) m_ovf = 1'b1;
            else m_push(code_data);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit pres;
            int l;
            pres = m_presented();
            l = (m_q.size() > 0) ? tb_len(m_q[0]) : 0;
            chk("m_valid", 32'(instr_valid), 32'(pres));
            chk("m_ready", 32'(fetch_ready), 32'(!(pres && m_q.size() > l)));
            chk("m_ovf", 32'(overflow), 32'(m_ovf));
            if (pres) begin
                chk("m_ir", 32'(ir), 32'(m_q[0]));
                chk("m_len", 32'(instr_len), 32'(l));
                chk("m_rel", 32'(rel), 32'(m_rel));
                if (l >= 2) chk("m_opnd1", 32'(opnd1), 32'(m_q[1]));
                else        chk("m_opnd1", 32'(opnd1), 32'h0);
                if (l == 3) chk("m_opnd2", 32'(opnd2), 32'(m_q[2]));
                else        chk("m_opnd2", 32'(opnd2), 32'h0);
            end
        end
    end

    task automatic step(input logic v, input logic [7:0] d, input logic tk, input logic fl);
        code_valid = v;
        code_data  = d;
        instr_take = tk;
        flush      = fl;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        code_data  = 8'h00;
        instr_take = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic byte_in(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic take();
        step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, 32'(instr_valid), 32'h0);
        chk({tag, "_ready"}, 32'(fetch_ready), 32'h1);
        chk({tag, "_ir"},    32'(ir), 32'h00);
        chk({tag, "_opnd1"}, 32'(opnd1), 32'h00);
        chk({tag, "_opnd2"}, 32'(opnd2), 32'h00);
        chk({tag, "_rel"},   32'(rel), 32'h0000);
        chk({tag, "_len"},   32'(instr_len), 32'h0);
        chk({tag, "_ovf"},   32'(overflow), 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        code_valid = 1'b0;
        code_data = 8'h00;
        flush = 1'b0;
        instr_take = 1'b0;
        dec_op = 8'h00;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk_reset_state("rst");
        reset = 1'b0;
        chk_en = 1'b1;

        // 2-byte direct instruction
        byte_in(8'hE5);
        byte_in(8'h30);
        chk("t1_valid", 32'(instr_valid), 32'h1);
        chk("t1_ir",    32'(ir), 32'hE5);
        chk("t1_opnd1", 32'(opnd1), 32'h30);
        chk("t1_len",   32'(instr_len), 32'h2);
        chk("t1_rel",   32'(rel), 32'h0030);
        take();
        chk("t1_taken", 32'(instr_valid), 32'h0);

        // 3-byte MOV dir,dir; one held byte, then an overflow
        byte_in(8'h85);
        byte_in(8'h40);
        byte_in(8'h50);
        chk("t2_len",   32'(instr_len), 32'h3);
        chk("t2_opnd1", 32'(opnd1), 32'h40);
        chk("t2_opnd2", 32'(opnd2), 32'h50);
        byte_in(8'h00);
        chk("t2_ready", 32'(fetch_ready), 32'h0);
        chk("t2_ovf0",  32'(overflow), 32'h0);
        byte_in(8'h11);
        chk("t2_ovf1",  32'(overflow), 32'h1);
        chk("t2_ir",    32'(ir), 32'h85);

        // take with a held 1-byte opcode and a new byte together
        step(1'b1, 8'h04, 1'b1, 1'b0);
        chk("t3_ir",    32'(ir), 32'h00);
        chk("t3_valid", 32'(instr_valid), 32'h1);
        chk("t3_ready", 32'(fetch_ready), 32'h0);
        take();
        chk("t3_ir2",   32'(ir), 32'h04);
        chk("t3_ready2", 32'(fetch_ready), 32'h1);
        take();

        // SJMP with negative offset, then take with a same-cycle 1-byte opcode
        byte_in(8'h80);
        byte_in(8'hFE);
        chk("t4_rel",   32'(rel), 32'hFFFE);
        chk("t4_len",   32'(instr_len), 32'h2);
        step(1'b1, 8'hE4, 1'b1, 1'b0);
        chk("t4_ir2",   32'(ir), 32'hE4);
        chk("t4_rel2",  32'(rel), 32'hFFFE);
        take();

        // flush mid-instruction drops the same-cycle byte
        byte_in(8'h02);
        byte_in(8'h12);
        step(1'b1, 8'h34, 1'b0, 1'b1);
        chk("t5_valid", 32'(instr_valid), 32'h0);
        chk("t5_ir",    32'(ir), 32'h00);
        chk("t5_ovf",   32'(overflow), 32'h1);
        byte_in(8'h04);
        chk("t5_ir2",   32'(ir), 32'h04);
        chk("t5_len2",  32'(instr_len), 32'h1);
        take();

        // take ignored while incomplete; held multi-byte opcode absorbs a same-cycle operand
        byte_in(8'h74);
        take();
        byte_in(8'h99);
        chk("t7_opnd1", 32'(opnd1), 32'h99);
        byte_in(8'h90);
        step(1'b1, 8'h11, 1'b1, 1'b0);
        chk("t7_ir",    32'(ir), 32'h90);
        chk("t7_valid", 32'(instr_valid), 32'h0);
        byte_in(8'h22);
        chk("t7_opnd2", 32'(opnd2), 32'h22);
        chk("t7_rel",   32'(rel), 32'h0022);
        take();

        // reset mid-instruction
        byte_in(8'h75);
        byte_in(8'h20);
        chk_en = 1'b0;
        reset = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk_reset_state("t6");
        reset = 1'b0;
        chk_en = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk_en = 1'b0;

        // length decoder over every opcode
        for (int i = 0; i < 256; i++) begin
            dec_op = 8'(i);
            #1;
            chk("dec_len", 32'(dec_len), 32'(tb_len(8'(i))));
        end
        chk("dec_85", 32'(tb_len(8'h85)) + 32'(dec_len) * 0, 32'h3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
